// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and start-bit glitch rejection.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int CLOCK_FREQ = 27_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_pin,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int CPB = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          par_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= i_rx_pin;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par_bad     <= 1'b0;
      o_data      <= 8'h00;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt     <= '0;
          par_bad <= 1'b0;
          if (!rx_s) begin
            state  <= START;
            o_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt <= '0;
            idx <= '0;
            if (rx_s) begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            par_bad <= ^{shreg, rx_s};
            state   <= STOP;
          end else begin
            cnt <= cnt + ONE;
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so the next start edge is caught promptly
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              if (!par_bad) begin
                o_data  <= shreg;
                o_valid <= 1'b1;
              end
              state  <= IDLE;
              o_busy <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + ONE;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_parity_err <= 1'b0;
    end else begin
      o_parity_err <= (state == STOP) && (cnt == LAST)
                      && rx_s && par_bad;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 27 MHz / 115200 baud.
// Define UART_RX_PARITY_EN on both files to exercise the parity build.
module tb_uart_rx;

  localparam int CPB = 234;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rx_pin = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] vq[$];
  int         vt[$];
  int         ferr_n = 0;
  int         perr_n = 0;

  uart_rx #(.CLOCK_FREQ(27_000_000), .BAUD_RATE(115_200)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_pin    (i_rx_pin),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_parity_err(o_parity_err),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      vq.push_back(o_data);
      vt.push_back(cyc);
    end
    if (o_frame_err) ferr_n = ferr_n + 1;
    if (o_parity_err) perr_n = perr_n + 1;
  end

  task automatic clear_mon();
    vq.delete();
    vt.delete();
    ferr_n = 0;
    perr_n = 0;
  endtask

  task automatic hold(input logic v, input int n);
    i_rx_pin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input bit par_en, input logic par);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    if (par_en) hold(par, CPB);
    hold(stop, CPB);
    i_rx_pin = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (o_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", o_data);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", o_valid);
    end
    checks++;
    if (o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ferr got %b want 0", o_frame_err);
    end
    checks++;
    if (o_parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_perr got %b want 0", o_parity_err);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", o_busy);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    int lat;
    clear_mon();
    t0 = cyc;
    send_frame(8'h48, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (vq.size() != 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", vq.size());
    end else begin
      lat = vt[0] - t0;
      checks++;
      if (vq[0] !== 8'h48) begin
        errors++;
        $display("FAIL single_data got %h want 48", vq[0]);
      end
      checks++;
      if (lat < 2225 || lat > 2227) begin
        errors++;
        $display("FAIL single_latency got %0d want 2226+/-1", lat);
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy got %b want 0", o_busy);
    end
    checks++;
    if (o_data !== 8'h48) begin
      errors++;
      $display("FAIL single_hold got %h want 48", o_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[14];
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
            8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0A};
    clear_mon();
    for (int i = 0; i < 14; i++) send_frame(msg[i], 1'b1, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    checks++;
    if (vq.size() != 14) begin
      errors++;
      $display("FAIL b2b_count got %0d want 14", vq.size());
    end else begin
      for (int i = 0; i < 14; i++) begin
        checks++;
        if (vq[i] !== msg[i]) begin
          errors++;
          $display("FAIL b2b_byte%0d got %h want %h", i, vq[i], msg[i]);
        end
      end
    end
    checks++;
    if (ferr_n != 0 || perr_n != 0) begin
      errors++;
      $display("FAIL b2b_errs got %0d/%0d want 0/0", ferr_n, perr_n);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    hold(1'b0, 30);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL glitch_busy_hi got %b want 1", o_busy);
    end
    hold(1'b0, 20);
    hold(1'b1, 120);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_lo got %b want 0", o_busy);
    end
    hold(1'b1, 2500);
    checks++;
    if (vq.size() != 0 || ferr_n != 0 || perr_n != 0) begin
      errors++;
      $display("FAIL glitch_pulses got v%0d f%0d p%0d want 0",
               vq.size(), ferr_n, perr_n);
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(((8'hA5 >> i) & 8'h01) != 0, CPB);
    hold(1'b0, CPB + 3000);
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL ferr_busy got %b want 1", o_busy);
    end
    hold(1'b1, 500);
    checks++;
    if (ferr_n != 1) begin
      errors++;
      $display("FAIL ferr_count got %0d want 1", ferr_n);
    end
    checks++;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL ferr_valid got %0d want 0", vq.size());
    end
    checks++;
    if (o_data !== 8'h0A) begin
      errors++;
      $display("FAIL ferr_data got %h want 0a", o_data);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_idle got %b want 0", o_busy);
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    hold(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(((8'h3C >> i) & 8'h01) != 0, CPB);
    hold(1'b1, 100);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_busy got %b want 0", o_busy);
    end
    rst = 1'b0;
    hold(1'b1, 300);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    checks++;
    if (vq.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count got %0d want 1", vq.size());
    end else begin
      checks++;
      if (vq[0] !== 8'h81) begin
        errors++;
        $display("FAIL rstmid_data got %h want 81", vq[0]);
      end
    end
    checks++;
    if (ferr_n != 0 || perr_n != 0) begin
      errors++;
      $display("FAIL rstmid_errs got %0d/%0d want 0/0", ferr_n, perr_n);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    checks++;
    if (perr_n != 1 || vq.size() != 0) begin
      errors++;
      $display("FAIL par_bad got p%0d v%0d want p1 v0", perr_n, vq.size());
    end
    checks++;
    if (o_data !== 8'h81) begin
      errors++;
      $display("FAIL par_hold got %h want 81", o_data);
    end
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    repeat (200) @(negedge clk);
    checks++;
    if (perr_n != 0 || vq.size() != 1) begin
      errors++;
      $display("FAIL par_good got p%0d v%0d want p0 v1", perr_n, vq.size());
    end else begin
      checks++;
      if (vq[0] !== 8'h07) begin
        errors++;
        $display("FAIL par_data got %h want 07", vq[0]);
      end
    end
  endtask
`else
  task automatic test_parity();
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    checks++;
    if (perr_n != 0 || vq.size() != 1) begin
      errors++;
      $display("FAIL nopar got p%0d v%0d want p0 v1", perr_n, vq.size());
    end else begin
      checks++;
      if (vq[0] !== 8'h07) begin
        errors++;
        $display("FAIL nopar_data got %h want 07", vq[0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
